// File: rtl/stream_chk_pkg.sv
// Shared types and CRC-8 helper for the stream sink checker.
// The CRC step is MSB-first, unreflected, with no final XOR.
package stream_chk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StCheck,
        StDone
    } state_e;

    localparam logic [7:0] CrcPolyDefault = 8'h07;
    localparam logic [7:0] CrcInitDefault = 8'h00;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data,
                                             input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/sink_crc8.sv
// Registered CRC-8 accumulator. When init is high the seed is loaded;
// otherwise, when en is high, one data byte is folded in. Either takes effect on the next clock.
module sink_crc8
    import stream_chk_pkg::*;
#(
    parameter logic [7:0] CRC_POLY = CrcPolyDefault,
    parameter logic [7:0] CRC_INIT = CrcInitDefault
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc8_step(crc_q, data, CRC_POLY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/stream_sink_checker.sv
// Receive-side stream checker. Once armed, it counts bytes and accumulates a CRC-8 signature,
// then reports pass or fail against the expected length and signature.
module stream_sink_checker
    import stream_chk_pkg::*;
#(
    parameter int unsigned LEN_W    = 16,
    parameter logic [7:0]  CRC_POLY = CrcPolyDefault,
    parameter logic [7:0]  CRC_INIT = CrcInitDefault,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] expected_len,
    input  logic [7:0]       expected_sig,
    input  logic [7:0]       data_in,
    input  logic             valid_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_timeout,
    output logic             err_sig,
    output logic [LEN_W-1:0] byte_count,
    output logic [7:0]       signature
);

    localparam int unsigned   IdleW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IdleW-1:0] IdleLastM1 = IdleW'(TIMEOUT - 2);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] exp_len_q, exp_len_d;
    logic [7:0]       exp_sig_q, exp_sig_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_sig_q, err_sig_d;
    logic             pass_q, pass_d;

    logic             crc_init;
    logic [7:0]       crc;
    logic             accept, last_byte, idle_hit, sig_mismatch, arm;

    assign arm          = start && (state_q == StIdle || state_q == StDone);
    assign accept       = valid_in && (state_q == StCapture);
    assign last_byte    = accept && (({1'b0, count_q} + (LEN_W + 1)'(1)) == {1'b0, exp_len_q});
    // Fires on the idle cycle that brings the counter to TIMEOUT-1.
    assign idle_hit     = (state_q == StCapture) && !valid_in && (idle_q == IdleLastM1);
    assign sig_mismatch = (crc != exp_sig_q);

    sink_crc8 #(
        .CRC_POLY(CRC_POLY),
        .CRC_INIT(CRC_INIT)
    ) u_crc (
        .clk  (clk),
        .rst_n(rst_n),
        .init (crc_init),
        .en   (accept),
        .data (data_in),
        .crc  (crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = (expected_len == '0) ? StCheck : StCapture;
                end
            end
            StCapture: begin
                if (last_byte || idle_hit) begin
                    state_d = StCheck;
                end
            end
            StCheck: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        exp_len_d     = exp_len_q;
        exp_sig_d     = exp_sig_q;
        count_d       = count_q;
        idle_d        = idle_q;
        err_timeout_d = err_timeout_q;
        err_sig_d     = err_sig_q;
        pass_d        = pass_q;
        crc_init      = 1'b0;
        if (arm) begin
            exp_len_d     = expected_len;
            exp_sig_d     = expected_sig;
            count_d       = '0;
            idle_d        = '0;
            err_timeout_d = 1'b0;
            err_sig_d     = 1'b0;
            pass_d        = 1'b0;
            crc_init      = 1'b1;
        end else if (state_q == StCapture) begin
            if (accept) begin
                count_d = (count_q == '1) ? count_q : count_q + 1'b1;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + 1'b1;
                if (idle_hit) begin
                    err_timeout_d = 1'b1;
                end
            end
        end else if (state_q == StCheck) begin
            err_sig_d = sig_mismatch;
            pass_d    = !err_timeout_q && !sig_mismatch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_len_q     <= '0;
            exp_sig_q     <= '0;
            count_q       <= '0;
            idle_q        <= '0;
            err_timeout_q <= 1'b0;
            err_sig_q     <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            exp_len_q     <= exp_len_d;
            exp_sig_q     <= exp_sig_d;
            count_q       <= count_d;
            idle_q        <= idle_d;
            err_timeout_q <= err_timeout_d;
            err_sig_q     <= err_sig_d;
            pass_q        <= pass_d;
        end
    end

    // The verdict is presented in the same cycle as the done pulse, then held from the registers.
    always_comb begin
        ready       = (state_q == StCapture);
        busy        = (state_q == StCapture) || (state_q == StCheck);
        done        = (state_q == StCheck);
        pass        = (state_q == StCheck) ? (!err_timeout_q && !sig_mismatch) : pass_q;
        err_sig     = (state_q == StCheck) ? sig_mismatch : err_sig_q;
        err_timeout = err_timeout_q;
        byte_count  = count_q;
        signature   = crc;
    end

endmodule

// File: tb/tb_stream_sink_checker.sv
// Scoreboard bench for stream_sink_checker. Expected verdicts come from a GF(2) long-division
// CRC model and are queued at stimulus time. A monitor pops one verdict per done pulse.
module tb_stream_sink_checker;

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned TIMEOUT = 16;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic        pass_v;
        logic        esig;
        logic        eto;
        logic [15:0] cnt;
        logic [7:0]  sig;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] expected_len = '0;
    logic [7:0]       expected_sig = '0;
    logic [7:0]       data_in = '0;
    logic             valid_in = 1'b0;
    logic             ready, busy, done, pass, err_timeout, err_sig;
    logic [LEN_W-1:0] byte_count;
    logic [7:0]       signature;

    int      checks = 0;
    int      errors = 0;
    exp_t    sb_q[$];
    exp_t    mon_e;
    exp_t    last_exp;
    byte_q_t txn_bytes;

    always #5 clk = ~clk;

    stream_sink_checker #(
        .LEN_W   (LEN_W),
        .CRC_POLY(8'h07),
        .CRC_INIT(8'h00),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .expected_len(expected_len),
        .expected_sig(expected_sig),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_timeout (err_timeout),
        .err_sig     (err_sig),
        .byte_count  (byte_count),
        .signature   (signature)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // CRC as the remainder of msg(x) * x^8 divided by x^8 + x^2 + x + 1 (zero seed).
    function automatic logic [7:0] ref_crc(input byte_q_t msg, input int n);
        logic [8:0] rem;
        logic       b;
        rem = '0;
        for (int i = 0; i < n * 8 + 8; i++) begin
            b   = (i < n * 8) ? msg[i / 8][7 - (i % 8)] : 1'b0;
            rem = {rem[7:0], b};
            if (rem[8]) rem = rem ^ 9'h107;
        end
        return rem[7:0];
    endfunction

    function automatic exp_t model(input byte_q_t msg, input int len, input int sent,
                                   input logic [7:0] sig);
        exp_t e;
        e.sig    = ref_crc(msg, sent);
        e.eto    = (sent < len);
        e.esig   = (e.sig != sig);
        e.pass_v = !e.eto && !e.esig;
        e.cnt    = 16'(sent);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, want no pending verdict");
            end else begin
                mon_e = sb_q.pop_front();
                chk("verdict_pass", 32'(pass), 32'(mon_e.pass_v));
                chk("verdict_err_sig", 32'(err_sig), 32'(mon_e.esig));
                chk("verdict_err_timeout", 32'(err_timeout), 32'(mon_e.eto));
                chk("verdict_byte_count", 32'(byte_count), 32'(mon_e.cnt));
                chk("verdict_signature", 32'(signature), 32'(mon_e.sig));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
        chk({tag, "_err_sig"}, 32'(err_sig), 0);
        chk({tag, "_byte_count"}, 32'(byte_count), 0);
        chk({tag, "_signature"}, 32'(signature), 0);
    endtask

    task automatic do_start(input int len, input logic [7:0] sig);
        start        = 1'b1;
        expected_len = LEN_W'(len);
        expected_sig = sig;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        valid_in = 1'b1;
        data_in  = d;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = 8'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got no done within %0d cycles, want done", cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic queue_expect(input int len, input int sent, input logic [7:0] sig);
        last_exp = model(txn_bytes, len, sent, sig);
        sb_q.push_back(last_exp);
    endtask

    task automatic run_txn(input int len, input int sent, input logic [7:0] sig,
                           input int gapmax, output int cyc);
        queue_expect(len, sent, sig);
        do_start(len, sig);
        for (int i = 0; i < sent; i++) send(txn_bytes[i], $urandom_range(0, gapmax));
        wait_done(cyc);
    endtask

    initial begin
        int cyc;
        int len;
        int sent;
        logic [7:0] sig;

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1) Three back-to-back bytes with the signature that matches.
        txn_bytes = '{8'h10, 8'h20, 8'hFF};
        queue_expect(3, 3, 8'hFF);
        do_start(3, 8'hFF);
        chk("t1_ready", 32'(ready), 1);
        send(8'h10, 0);
        chk("t1_sig0", 32'(signature), 32'h70);
        send(8'h20, 0);
        chk("t1_sig1", 32'(signature), 32'hB7);
        send(8'hFF, 0);
        chk("t1_sig2", 32'(signature), 32'hFF);
        chk("t1_done_latency", 32'(done), 1);
        wait_done(cyc);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_pass_held", 32'(pass), 32'(last_exp.pass_v));

        // 2) Same stream against the wrong signature.
        run_txn(3, 3, 8'h00, 0, cyc);
        chk("t2_err_sig_held", 32'(err_sig), 1);

        // 3) Valid bytes before start are ignored; one byte after 5 idle cycles.
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            data_in  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        chk("t3_ignored_count", 32'(byte_count), 3);
        txn_bytes = '{8'h01};
        queue_expect(1, 1, 8'h07);
        do_start(1, 8'h07);
        send(8'h01, 5);
        chk("t3_sig", 32'(signature), 32'h07);
        wait_done(cyc);

        // 4) Stream stalls after 2 of 4 bytes, so the idle limit fires.
        txn_bytes = '{8'h5A, 8'hC3, 8'h11, 8'h22};
        queue_expect(4, 2, ref_crc(txn_bytes, 4));
        do_start(4, ref_crc(txn_bytes, 4));
        send(txn_bytes[0], 0);
        send(txn_bytes[1], 1);
        wait_done(cyc);
        chk("t4_timeout_latency", 32'(cyc), TIMEOUT - 1);
        chk("t4_err_timeout_held", 32'(err_timeout), 1);

        // 5) Reset mid-capture discards the partial result.
        txn_bytes = '{8'hA1, 8'hB2, 8'hC3};
        queue_expect(3, 3, ref_crc(txn_bytes, 3));
        do_start(3, ref_crc(txn_bytes, 3));
        send(txn_bytes[0], 0);
        send(txn_bytes[1], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t5_midreset");
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_txn(3, 3, ref_crc(txn_bytes, 3), 0, cyc);
        chk("t5_pass_after", 32'(pass), 1);

        // 6) Zero length finishes at once; a start during capture has no effect.
        txn_bytes = {};
        run_txn(0, 0, 8'h00, 0, cyc);
        chk("t6_zero_len_latency", 32'(cyc), 0);
        txn_bytes = '{8'h3C, 8'h96};
        queue_expect(2, 2, ref_crc(txn_bytes, 2));
        do_start(2, ref_crc(txn_bytes, 2));
        send(txn_bytes[0], 0);
        start        = 1'b1;
        expected_len = '0;
        expected_sig = 8'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        send(txn_bytes[1], 0);
        wait_done(cyc);

        // Randomized transactions with occasional early stalls and noise while idle.
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(0, 8);
            txn_bytes = {};
            for (int i = 0; i < len; i++) txn_bytes.push_back(8'($urandom));
            sent = (len > 0 && ($urandom % 5) == 0) ? $urandom_range(0, len - 1) : len;
            sig  = ($urandom % 2) ? ref_crc(txn_bytes, len) : 8'($urandom);
            repeat ($urandom_range(0, 2)) begin
                valid_in = 1'b1;
                data_in  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            valid_in = 1'b0;
            run_txn(len, sent, sig, 3, cyc);
        end

        chk("scoreboard_empty", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by 2ms, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
